spi_to_uart: RTL and testbench
==============================

SPI_TO_UART -- requirements
Module: spi_to_uart

Interface
REQ-001 Parameter CLK_DIV, default 1042, SHALL set clk cycles per UART bit (96 kbps at 100 MHz).
REQ-002 Parameter TXQ_DEPTH, default 4, fixed power of two, SHALL set the SPI-to-UART byte FIFO depth.
REQ-003 clk  input  1  single system clock; all logic SHALL run on its rising edge.
REQ-004 resetn  input  1  reset, asynchronous and active-low.
REQ-005 spi_csb  input  1  SPI chip select from external master, active low.
REQ-006 spi_sck  input  1  SPI clock, mode 0, asynchronous to clk, high or low time >= 4 clk.
REQ-007 spi_sdi  input  1  master-to-slave data, MSB first.
REQ-008 spi_sdo  output  1  slave-to-master data, MSB first, always driven.
REQ-009 ser_tx  output  1  UART transmit, 8N1, LSB first.
REQ-010 ser_rx  input  1  UART receive, 8N1, LSB first, asynchronous.
REQ-011 tx_overrun  output  1  sticky: an SPI byte was dropped because the FIFO was full.
REQ-012 rx_overrun  output  1  sticky: a UART byte overwrote an unread holding byte.

Function
REQ-013 spi_csb, spi_sck, spi_sdi and ser_rx SHALL each pass a 2-flop synchronizer; edges are detected on synchronized values.
REQ-014 Falling edge of csb SHALL clear the bit counter (0..7) and drive spi_sdo with bit 7 of the return byte.
REQ-015 Return byte: the RX holding byte if valid, which clears valid; otherwise 8'hFF.
REQ-016 While csb is low, each sck rise SHALL shift sdi into the receive shift register and increment the bit counter.
REQ-017 On the 8th sck rise, the assembled byte SHALL be pushed to the TX FIFO; if the FIFO is full, the byte is dropped and tx_overrun is set.
REQ-018 Each sck fall SHALL present the next return bit on spi_sdo; the fall after the 8th rise SHALL load a new return byte per REQ-015 and present its bit 7.
REQ-019 Rising edge of csb SHALL abort a partial byte: no push, counter cleared, spi_sdo=1; held return bits are discarded.
REQ-020 Edges on sck while csb is high SHALL be ignored.
REQ-021 TX FIFO: push and pop in the same cycle SHALL both take effect; on full with simultaneous pop, the push is accepted; pointers wrap modulo TXQ_DEPTH.
REQ-022 UART TX states: IDLE, START, DATA, STOP.
REQ-023 IDLE: ser_tx=1; if the FIFO is non-empty, pop into the shift register and go to START.
REQ-024 START, each DATA bit, and STOP SHALL each last exactly CLK_DIV cycles, making a frame 10*CLK_DIV cycles.
REQ-025 After STOP, TX SHALL return to IDLE; back-to-back frames SHALL have no extra gap beyond one clk.
REQ-026 UART RX states: IDLE, START, DATA, STOP.
REQ-027 RX IDLE -> START on synchronized ser_rx=0.
REQ-028 START SHALL wait CLK_DIV/2 cycles (integer division) and resample; if ser_rx=1, it is a false start and RX returns to IDLE.
REQ-029 DATA SHALL sample 8 bits, each CLK_DIV cycles after the previous sample, LSB first.
REQ-030 STOP SHALL sample after CLK_DIV cycles; if 1, the byte goes to the holding register with valid=1, and rx_overrun is set if valid was already 1; if 0, it is a framing error and the byte is discarded.
REQ-031 RX SHALL then return to IDLE.
REQ-032 A holding-register write and a return-byte load in the same cycle SHALL resolve as: the load takes the old byte and valid stays 1 with the new byte, with no overrun flagged.
REQ-033 All counters SHALL be 16 bits wide; CLK_DIV >= 16 is required.

Reset
REQ-034 resetn low SHALL asynchronously force: spi_sdo=1, ser_tx=1, tx_overrun=0, rx_overrun=0, FIFO empty, holding valid=0, both UART FSMs IDLE, bit counter 0, synchronizers to idle levels (csb=1, sck=0, rx=1).
REQ-035 Reset mid-frame or mid-SPI-byte SHALL discard all partial data; after release, operation begins at the next csb fall or start bit.

Verification
REQ-036 CLK_DIV=16, SPI sends 8'hA5 with csb low -> ser_tx frame start 0, bits 1,0,1,0,0,1,0,1, stop 1, 160 clk total; spi_sdo returns 8'hFF.
REQ-037 UART receives 8'h3C, then SPI transfers one byte -> spi_sdo shifts 0,0,1,1,1,1,0,0; the next byte returns 8'hFF.
REQ-038 Five SPI bytes 01..05 sent faster than UART drains, TXQ_DEPTH=4 -> observe whether the in-flight pop frees a slot; ser_tx order matches accepted bytes; tx_overrun=1 only if a byte was dropped.
REQ-039 Two UART bytes 11, 22 with no SPI read -> rx_overrun=1; the next SPI read returns 8'h22.
REQ-040 ser_rx low pulse of CLK_DIV/4 cycles -> no byte captured; corrupt stop bit (0) -> byte discarded, valid stays 0.
REQ-041 csb raised after 5 sck edges, then a full byte 8'h7E -> only 8'h7E appears on ser_tx; resetn pulsed mid-frame -> ser_tx=1 immediately.

Source files
------------

// File: rtl/spi_to_uart.sv
// spi_to_uart: SPI mode-0 slave bridged to an 8N1 UART.
//   Bytes written by the SPI master are queued in a small FIFO and
//   transmitted on ser_tx. Bytes received on ser_rx land in a one-byte
//   holding register that the SPI master reads back on spi_sdo
//   (8'hFF when nothing is held).
// Ports:
//   clk, resetn                  system clock, async active-low reset
//   spi_csb, spi_sck, spi_sdi    SPI from external master (asynchronous)
//   spi_sdo                      SPI return data, MSB first
//   ser_tx / ser_rx              UART transmit / receive, LSB first
//   tx_overrun                   sticky: SPI byte dropped, FIFO full
//   rx_overrun                   sticky: unread holding byte overwritten
module spi_to_uart #(
  parameter int unsigned CLK_DIV   = 1042,
  parameter int unsigned TXQ_DEPTH = 4
) (
  input  logic clk,
  input  logic resetn,
  input  logic spi_csb,
  input  logic spi_sck,
  input  logic spi_sdi,
  output logic spi_sdo,
  output logic ser_tx,
  input  logic ser_rx,
  output logic tx_overrun,
  output logic rx_overrun
);

  localparam int unsigned AW      = $clog2(TXQ_DEPTH);
  localparam logic [15:0] DIV_M1  = 16'(CLK_DIV - 1);
  localparam logic [15:0] HALF_M1 = 16'((CLK_DIV / 2) - 1);

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;

  // Synchronizers and edge detection
  logic [1:0] csb_sync_q, sck_sync_q, sdi_sync_q, rx_sync_q;
  logic       csb_prev_q, sck_prev_q;
  logic       csb_s, sck_s, sdi_s, rx_s;
  logic       csb_fall, csb_rise, sck_rise, sck_fall;

  assign csb_s    = csb_sync_q[1];
  assign sck_s    = sck_sync_q[1];
  assign sdi_s    = sdi_sync_q[1];
  assign rx_s     = rx_sync_q[1];
  assign csb_fall = csb_prev_q & ~csb_s;
  assign csb_rise = ~csb_prev_q & csb_s;
  assign sck_rise = ~sck_prev_q & sck_s & ~csb_s;
  assign sck_fall = sck_prev_q & ~sck_s & ~csb_s;

  // SPI slave state
  logic [15:0] bit_cnt_q, bit_cnt_d;
  logic [6:0]  rx_sr_q, rx_sr_d;
  logic [7:0]  ret_sr_q, ret_sr_d;
  logic        byte_done_q, byte_done_d;
  logic        sdo_q, sdo_d;
  logic        spi_push, ret_load;
  logic [7:0]  spi_byte, ret_byte;

  // Holding register
  logic [7:0] hold_q, hold_d;
  logic       hold_valid_q, hold_valid_d;
  logic       rx_ov_q, rx_ov_d;

  // TX FIFO
  logic [7:0]  mem_q [TXQ_DEPTH];
  logic [AW:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic        fifo_empty, fifo_full, push_ok, tx_pop;
  logic        tx_ov_q, tx_ov_d;

  // UART TX
  tx_state_e   tx_state_q, tx_state_d;
  logic [15:0] tx_cnt_q, tx_cnt_d, tx_bit_q, tx_bit_d;
  logic [7:0]  tx_sh_q, tx_sh_d;

  // UART RX
  rx_state_e   rx_state_q, rx_state_d;
  logic [15:0] rx_cnt_q, rx_cnt_d, rx_bit_q, rx_bit_d;
  logic [7:0]  rx_sh_q, rx_sh_d;
  logic        rx_wr;

  assign ret_byte = hold_valid_q ? hold_q : 8'hFF;
  assign spi_byte = {rx_sr_q, sdi_s};

  // SPI shift logic: csb edges take priority over sck edges.
  always_comb begin
    bit_cnt_d   = bit_cnt_q;
    rx_sr_d     = rx_sr_q;
    ret_sr_d    = ret_sr_q;
    byte_done_d = byte_done_q;
    sdo_d       = sdo_q;
    spi_push    = 1'b0;
    ret_load    = 1'b0;
    if (csb_rise) begin
      bit_cnt_d   = '0;
      byte_done_d = 1'b0;
      sdo_d       = 1'b1;
    end else if (csb_fall) begin
      bit_cnt_d   = '0;
      byte_done_d = 1'b0;
      ret_load    = 1'b1;
      ret_sr_d    = ret_byte;
      sdo_d       = ret_byte[7];
    end else if (sck_rise) begin
      rx_sr_d = {rx_sr_q[5:0], sdi_s};
      if (bit_cnt_q == 16'd7) begin
        bit_cnt_d   = '0;
        spi_push    = 1'b1;
        byte_done_d = 1'b1;
      end else begin
        bit_cnt_d = bit_cnt_q + 16'd1;
      end
    end else if (sck_fall) begin
      if (byte_done_q) begin
        byte_done_d = 1'b0;
        ret_load    = 1'b1;
        ret_sr_d    = ret_byte;
        sdo_d       = ret_byte[7];
      end else begin
        ret_sr_d = {ret_sr_q[6:0], 1'b1};
        sdo_d    = ret_sr_q[6];
      end
    end
  end

  // A UART write coinciding with a return load: the load has already taken
  // the old byte, so the new one stays valid and is not an overrun.
  always_comb begin
    hold_d       = hold_q;
    hold_valid_d = hold_valid_q;
    rx_ov_d      = rx_ov_q;
    if (rx_wr) begin
      hold_d       = rx_sh_q;
      hold_valid_d = 1'b1;
      if (hold_valid_q && !ret_load) rx_ov_d = 1'b1;
    end else if (ret_load) begin
      hold_valid_d = 1'b0;
    end
  end

  // FIFO: a pop in the same cycle frees the slot for a push into a full queue.
  always_comb begin
    fifo_empty = (wr_ptr_q == rd_ptr_q);
    fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    push_ok    = spi_push && (!fifo_full || tx_pop);
    tx_ov_d    = tx_ov_q | (spi_push & fifo_full & ~tx_pop);
    wr_ptr_d   = push_ok ? wr_ptr_q + {{AW{1'b0}}, 1'b1} : wr_ptr_q;
    rd_ptr_d   = tx_pop  ? rd_ptr_q + {{AW{1'b0}}, 1'b1} : rd_ptr_q;
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= spi_byte;
  end

  // UART TX FSM
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_sh_d    = tx_sh_q;
    tx_pop     = 1'b0;
    unique case (tx_state_q)
      TX_IDLE: begin
        if (!fifo_empty) begin
          tx_pop     = 1'b1;
          tx_sh_d    = mem_q[rd_ptr_q[AW-1:0]];
          tx_cnt_d   = '0;
          tx_state_d = TX_START;
        end
      end
      TX_START: begin
        if (tx_cnt_q == DIV_M1) begin
          tx_cnt_d   = '0;
          tx_bit_d   = '0;
          tx_state_d = TX_DATA;
        end else begin
          tx_cnt_d = tx_cnt_q + 16'd1;
        end
      end
      TX_DATA: begin
        if (tx_cnt_q == DIV_M1) begin
          tx_cnt_d = '0;
          tx_sh_d  = {1'b1, tx_sh_q[7:1]};
          if (tx_bit_q == 16'd7) tx_state_d = TX_STOP;
          else                   tx_bit_d   = tx_bit_q + 16'd1;
        end else begin
          tx_cnt_d = tx_cnt_q + 16'd1;
        end
      end
      TX_STOP: begin
        if (tx_cnt_q == DIV_M1) begin
          tx_cnt_d   = '0;
          tx_state_d = TX_IDLE;
        end else begin
          tx_cnt_d = tx_cnt_q + 16'd1;
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

  always_comb begin
    ser_tx = 1'b1;
    unique case (tx_state_q)
      TX_START: ser_tx = 1'b0;
      TX_DATA:  ser_tx = tx_sh_q[0];
      default:  ser_tx = 1'b1;
    endcase
  end

  // UART RX FSM: centre-sampling after the half-bit start check.
  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_sh_d    = rx_sh_q;
    rx_wr      = 1'b0;
    unique case (rx_state_q)
      RX_IDLE: begin
        if (!rx_s) begin
          rx_cnt_d   = '0;
          rx_state_d = RX_START;
        end
      end
      RX_START: begin
        if (rx_cnt_q == HALF_M1) begin
          rx_cnt_d = '0;
          rx_bit_d = '0;
          rx_state_d = rx_s ? RX_IDLE : RX_DATA;
        end else begin
          rx_cnt_d = rx_cnt_q + 16'd1;
        end
      end
      RX_DATA: begin
        if (rx_cnt_q == DIV_M1) begin
          rx_cnt_d = '0;
          rx_sh_d  = {rx_s, rx_sh_q[7:1]};
          if (rx_bit_q == 16'd7) rx_state_d = RX_STOP;
          else                   rx_bit_d   = rx_bit_q + 16'd1;
        end else begin
          rx_cnt_d = rx_cnt_q + 16'd1;
        end
      end
      RX_STOP: begin
        if (rx_cnt_q == DIV_M1) begin
          rx_cnt_d   = '0;
          rx_wr      = rx_s;
          rx_state_d = RX_IDLE;
        end else begin
          rx_cnt_d = rx_cnt_q + 16'd1;
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      csb_sync_q   <= '1;
      sck_sync_q   <= '0;
      sdi_sync_q   <= '0;
      rx_sync_q    <= '1;
      csb_prev_q   <= 1'b1;
      sck_prev_q   <= 1'b0;
      bit_cnt_q    <= '0;
      rx_sr_q      <= '0;
      ret_sr_q     <= '1;
      byte_done_q  <= 1'b0;
      sdo_q        <= 1'b1;
      hold_q       <= '0;
      hold_valid_q <= 1'b0;
      rx_ov_q      <= 1'b0;
      tx_ov_q      <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      tx_state_q   <= TX_IDLE;
      tx_cnt_q     <= '0;
      tx_bit_q     <= '0;
      tx_sh_q      <= '1;
      rx_state_q   <= RX_IDLE;
      rx_cnt_q     <= '0;
      rx_bit_q     <= '0;
      rx_sh_q      <= '0;
    end else begin
      csb_sync_q   <= {csb_sync_q[0], spi_csb};
      sck_sync_q   <= {sck_sync_q[0], spi_sck};
      sdi_sync_q   <= {sdi_sync_q[0], spi_sdi};
      rx_sync_q    <= {rx_sync_q[0], ser_rx};
      csb_prev_q   <= csb_s;
      sck_prev_q   <= sck_s;
      bit_cnt_q    <= bit_cnt_d;
      rx_sr_q      <= rx_sr_d;
      ret_sr_q     <= ret_sr_d;
      byte_done_q  <= byte_done_d;
      sdo_q        <= sdo_d;
      hold_q       <= hold_d;
      hold_valid_q <= hold_valid_d;
      rx_ov_q      <= rx_ov_d;
      tx_ov_q      <= tx_ov_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      tx_state_q   <= tx_state_d;
      tx_cnt_q     <= tx_cnt_d;
      tx_bit_q     <= tx_bit_d;
      tx_sh_q      <= tx_sh_d;
      rx_state_q   <= rx_state_d;
      rx_cnt_q     <= rx_cnt_d;
      rx_bit_q     <= rx_bit_d;
      rx_sh_q      <= rx_sh_d;
    end
  end

  assign spi_sdo    = sdo_q;
  assign tx_overrun = tx_ov_q;
  assign rx_overrun = rx_ov_q;

endmodule

// File: tb/tb_spi_to_uart.sv
module tb_spi_to_uart;
  localparam int DIV   = 16;
  localparam int DEPTH = 4;
  localparam int FRAME = 10 * DIV + 1;

  logic clk, resetn, spi_csb, spi_sck, spi_sdi, spi_sdo;
  logic ser_tx, ser_rx, tx_overrun, rx_overrun;

  spi_to_uart #(.CLK_DIV(DIV), .TXQ_DEPTH(DEPTH)) dut (
    .clk(clk), .resetn(resetn), .spi_csb(spi_csb), .spi_sck(spi_sck),
    .spi_sdi(spi_sdi), .spi_sdo(spi_sdo), .ser_tx(ser_tx), .ser_rx(ser_rx),
    .tx_overrun(tx_overrun), .rx_overrun(rx_overrun)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int epoch = 0;
  always @(posedge clk) cyc++;

  logic [7:0] exp_tx[$];
  logic [7:0] exp_ret[$];
  logic [7:0] got_ret[$];
  logic [7:0] tx_bytes[8];

  // Reference model: holding byte, sticky flags, FIFO occupancy by time.
  logic [7:0] m_hold;
  logic       m_valid, m_txov, m_rxov;
  int         occ, busy_until;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] model_ret();
    if (m_valid) begin
      m_valid = 1'b0;
      return m_hold;
    end
    return 8'hFF;
  endfunction

  // UART drains one queued byte per frame; a byte arriving when idle starts at once.
  function automatic void model_push(input logic [7:0] b, input int t);
    while (occ > 0 && busy_until <= t) begin
      busy_until += FRAME;
      occ--;
    end
    if (occ == 0 && busy_until <= t) begin
      busy_until = t + FRAME;
      exp_tx.push_back(b);
    end else if (occ < DEPTH) begin
      occ++;
      exp_tx.push_back(b);
    end else begin
      m_txov = 1'b1;
    end
  endfunction

  function automatic void model_reset();
    epoch++;
    m_valid = 1'b0; m_hold = '0; m_txov = 1'b0; m_rxov = 1'b0;
    occ = 0; busy_until = 0;
    exp_tx.delete();
  endfunction

  task automatic spi_xfer(input int n, input int half);
    logic [7:0] cur, got;
    @(negedge clk) spi_csb = 1'b0;
    cur = model_ret();
    for (int b = 0; b < n; b++) begin
      exp_ret.push_back(cur);
      for (int i = 7; i >= 0; i--) begin
        spi_sdi = tx_bytes[b][i];
        repeat (half) @(negedge clk);
        got[i] = spi_sdo;
        spi_sck = 1'b1;
        if (i == 0) model_push(tx_bytes[b], cyc);
        repeat (half) @(negedge clk);
        spi_sck = 1'b0;
      end
      got_ret.push_back(got);
      cur = model_ret();
    end
    repeat (half) @(negedge clk);
    spi_csb = 1'b1;
    repeat (half) @(negedge clk);
  endtask

  task automatic spi_abort5();
    @(negedge clk) spi_csb = 1'b0;
    void'(model_ret());
    for (int i = 0; i < 5; i++) begin
      spi_sdi = 1'($urandom);
      repeat (6) @(negedge clk);
      spi_sck = 1'b1;
      repeat (6) @(negedge clk);
      spi_sck = 1'b0;
    end
    repeat (6) @(negedge clk);
    spi_csb = 1'b1;
    repeat (6) @(negedge clk);
    chk("sdo_after_abort", spi_sdo, 1);
  endtask

  // A corrupt stop bit is held low for 3/4 of a bit, then the line idles.
  task automatic uart_send(input logic [7:0] d, input logic stop);
    @(negedge clk) ser_rx = 1'b0;
    repeat (DIV) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      ser_rx = d[i];
      repeat (DIV) @(negedge clk);
    end
    ser_rx = stop;
    repeat (stop ? DIV : (DIV * 3) / 4) @(negedge clk);
    ser_rx = 1'b1;
    repeat (DIV + 4) @(negedge clk);
    if (stop) begin
      if (m_valid) m_rxov = 1'b1;
      m_hold = d;
      m_valid = 1'b1;
    end
  endtask

  task automatic drain();
    int w = 0;
    while (exp_tx.size() != 0 && w < 5000) begin
      @(negedge clk);
      w++;
    end
    chk("tx_drain_left", exp_tx.size(), 0);
    exp_tx.delete();
    repeat (30) @(negedge clk);
  endtask

  task automatic check_reset_outputs();
    chk("rst_ser_tx", ser_tx, 1);
    chk("rst_spi_sdo", spi_sdo, 1);
    chk("rst_tx_overrun", tx_overrun, 0);
    chk("rst_rx_overrun", rx_overrun, 0);
  endtask

  // UART TX monitor: centre-samples each frame and scores it.
  initial begin : tx_mon
    logic prev, ok;
    logic [7:0] d, e;
    int ep;
    prev = 1'b1;
    forever begin
      @(negedge clk);
      if (resetn && prev && !ser_tx) begin
        ep = epoch;
        ok = 1'b1;
        repeat (DIV / 2) @(negedge clk);
        if (ser_tx !== 1'b0) ok = 1'b0;
        for (int i = 0; i < 8; i++) begin
          repeat (DIV) @(negedge clk);
          d[i] = ser_tx;
        end
        repeat (DIV) @(negedge clk);
        if (ser_tx !== 1'b1) ok = 1'b0;
        if (ep == epoch) begin
          if (exp_tx.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL tx_unexpected: got %0h expected none", d);
          end else begin
            e = exp_tx.pop_front();
            chk("tx_byte", d, e);
            chk("tx_framing", ok, 1);
          end
        end
      end
      prev = ser_tx;
    end
  end

  // SPI return-data monitor
  initial begin : ret_mon
    logic [7:0] g;
    forever begin
      @(negedge clk);
      while (got_ret.size() > 0) begin
        g = got_ret.pop_front();
        if (exp_ret.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL spi_ret_unexpected: got %0h expected none", g);
        end else begin
          chk("spi_ret", g, exp_ret.pop_front());
        end
      end
    end
  end

  initial begin
    int w;
    clk = 1'b0; resetn = 1'b1; spi_csb = 1'b1; spi_sck = 1'b0; spi_sdi = 1'b0; ser_rx = 1'b1;
    model_reset();
    #3 resetn = 1'b0;
    #1 check_reset_outputs();
    repeat (5) @(negedge clk);
    resetn = 1'b1;
    repeat (5) @(negedge clk);

    // Single byte out, nothing held -> FF back
    tx_bytes[0] = 8'hA5;
    spi_xfer(1, 6);
    drain();

    // UART byte read back, then empty
    uart_send(8'h3C, 1'b1);
    tx_bytes[0] = 8'($urandom);
    spi_xfer(1, 6);
    tx_bytes[0] = 8'($urandom);
    spi_xfer(1, 5);
    drain();

    // Overwrite of an unread byte
    uart_send(8'h11, 1'b1);
    uart_send(8'h22, 1'b1);
    chk("rx_overrun_set", rx_overrun, m_rxov);
    tx_bytes[0] = 8'($urandom);
    spi_xfer(1, 6);
    drain();

    // Short glitch and framing error capture nothing
    @(negedge clk) ser_rx = 1'b0;
    repeat (DIV / 4) @(negedge clk);
    ser_rx = 1'b1;
    repeat (3 * DIV) @(negedge clk);
    tx_bytes[0] = 8'($urandom);
    spi_xfer(1, 6);
    uart_send(8'($urandom), 1'b0);
    tx_bytes[0] = 8'($urandom);
    spi_xfer(1, 6);
    drain();

    // Randomized mix
    for (int k = 0; k < 8; k++) begin
      int n;
      if ($urandom_range(1, 0) == 1) uart_send(8'($urandom), 1'b1);
      n = $urandom_range(3, 1);
      for (int i = 0; i < n; i++) tx_bytes[i] = 8'($urandom);
      spi_xfer(n, $urandom_range(7, 4));
      drain();
      chk("rx_overrun_rand", rx_overrun, m_rxov);
      chk("tx_overrun_rand", tx_overrun, m_txov);
    end

    // Burst faster than the UART drains
    for (int i = 0; i < 8; i++) tx_bytes[i] = 8'(i + 1);
    spi_xfer(8, 4);
    repeat (10) @(negedge clk);
    chk("tx_overrun_burst", tx_overrun, m_txov);
    drain();

    // Reset in the middle of a frame
    tx_bytes[0] = 8'h5A;
    spi_xfer(1, 6);
    w = 0;
    while (ser_tx !== 1'b0 && w < 500) begin
      @(negedge clk);
      w++;
    end
    chk("tx_start_seen", (w < 500), 1);
    repeat (40) @(negedge clk);
    resetn = 1'b0;
    model_reset();
    #1 check_reset_outputs();
    repeat (4) @(negedge clk);
    resetn = 1'b1;
    repeat (10) @(negedge clk);

    // Aborted partial byte, then a full one
    spi_abort5();
    tx_bytes[0] = 8'h7E;
    spi_xfer(1, 6);
    drain();
    repeat (300) @(negedge clk);
    chk("tx_overrun_end", tx_overrun, m_txov);
    chk("rx_overrun_end", rx_overrun, m_rxov);
    chk("ret_left", exp_ret.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
